// File: rtl/cm.sv
// cm: registered three-operand ALU (ADD3 / SUB / MAX3 / MAJ) with carry and zero flags
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   R0       operand A (unsigned, WIDTH bits)
//   R1       operand B (unsigned, WIDTH bits)
//   R2       operand C (unsigned, WIDTH bits)
//   opcode   00 ADD3, 01 SUB (R1-R2), 10 MAX3, 11 bitwise majority
//   R_EXTRA  registered result
//   carry    registered carry (ADD3) / borrow (SUB), 0 otherwise
//   zero     registered flag, 1 when R_EXTRA is all zeros
module cm #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] R0,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    input  logic [1:0]       opcode,
    output logic [WIDTH-1:0] R_EXTRA,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH+1:0] sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] max01, max3, maj, res;
    logic             cy;

    // two guard bits keep the full three-operand sum; the extra diff bit is the borrow
    always_comb begin
        sum   = {2'b00, R0} + {2'b00, R1} + {2'b00, R2};
        diff  = {1'b0, R1} - {1'b0, R2};
        max01 = (R0 > R1) ? R0 : R1;
        max3  = (max01 > R2) ? max01 : R2;
        maj   = (R0 & R1) | (R1 & R2) | (R0 & R2);
        res   = (opcode == 2'b00) ? sum[WIDTH-1:0] :
                (opcode == 2'b01) ? diff[WIDTH-1:0] :
                (opcode == 2'b10) ? max3 : maj;
        cy    = (opcode == 2'b00) ? |sum[WIDTH+1:WIDTH] :
                (opcode == 2'b01) ? diff[WIDTH] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_EXTRA <= '0;
            carry   <= 1'b0;
            zero    <= 1'b1;
        end else begin
            R_EXTRA <= res;
            carry   <= cy;
            zero    <= (res == '0);
        end
    end
endmodule

// File: tb/tb_cm.sv
// tb_cm: randomized self-checking bench for cm against an arithmetic reference model
module tb_cm;
    localparam int W = 3;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] R0 = '0, R1 = '0, R2 = '0;
    logic [1:0]   opcode = 2'b00;
    logic [W-1:0] R_EXTRA;
    logic         carry, zero;

    logic [W-1:0] er = '0;
    logic         ec = 1'b0, ez = 1'b1;

    int total = 0;
    int bad   = 0;

    cm #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .R0(R0), .R1(R1), .R2(R2),
        .opcode(opcode), .R_EXTRA(R_EXTRA), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    // reference: returns {carry, result} from plain integer arithmetic
    function automatic logic [W:0] model(input int a, input int b, input int c, input int op);
        int s, r, cy, n;
        int v[3];
        v[0] = a; v[1] = b; v[2] = c;
        r = 0; cy = 0;
        if (op == 0) begin
            s  = a + b + c;
            r  = s % M;
            cy = (s >= M) ? 1 : 0;
        end else if (op == 1) begin
            r  = (b - c + M) % M;
            cy = (b < c) ? 1 : 0;
        end else if (op == 2) begin
            for (int i = 0; i < 3; i++) if (v[i] > r) r = v[i];
        end else begin
            for (int k = 0; k < W; k++) begin
                n = 0;
                for (int i = 0; i < 3; i++) n += (v[i] >> k) & 1;
                if (n >= 2) r += 1 << k;
            end
        end
        return {cy[0], r[W-1:0]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [W:0] m;
        if (!rst_n) begin
            er <= '0;
            ec <= 1'b0;
            ez <= 1'b1;
        end else begin
            m  = model(int'(R0), int'(R1), int'(R2), int'(opcode));
            er <= m[W-1:0];
            ec <= m[W];
            ez <= (m[W-1:0] == '0);
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] xr, input logic xc, input logic xz);
        total++;
        if ({R_EXTRA, carry, zero} !== {xr, xc, xz}) begin
            bad++;
            $display("FAIL %s: got R_EXTRA=%0d carry=%0b zero=%0b, want R_EXTRA=%0d carry=%0b zero=%0b",
                     nm, R_EXTRA, carry, zero, xr, xc, xz);
        end
    endtask

    // called at a falling edge: junk inputs must not disturb outputs, then apply real inputs
    task automatic cyc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [1:0] op);
        R0 = W'($urandom); R1 = W'($urandom); R2 = W'($urandom); opcode = 2'($urandom);
        #1 chk("hold", er, ec, ez);
        R0 = a; R1 = b; R2 = c; opcode = op;
        @(negedge clk);
        chk("model", er, ec, ez);
    endtask

    task automatic lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [1:0] op,
                       input logic [W-1:0] xr, input logic xc, input logic xz);
        cyc(a, b, c, op);
        chk(nm, xr, xc, xz);
        total++;
        if ({er, ec, ez} !== {xr, xc, xz}) begin
            bad++;
            $display("FAIL model_%s: model R_EXTRA=%0d carry=%0b zero=%0b, want %0d %0b %0b",
                     nm, er, ec, ez, xr, xc, xz);
        end
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        repeat (2) @(negedge clk);
        chk("reset", 3'd0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1 chk("deassert_hold", 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("first_edge", er, ec, ez);

        lit("add3", 3'd1, 3'd4, 3'd2, 2'b00, 3'd7, 1'b0, 1'b0);
        lit("sub",  3'd1, 3'd4, 3'd2, 2'b01, 3'd2, 1'b0, 1'b0);
        lit("max3", 3'd1, 3'd4, 3'd2, 2'b10, 3'd4, 1'b0, 1'b0);
        lit("maj0", 3'd1, 3'd4, 3'd2, 2'b11, 3'd0, 1'b0, 1'b1);
        lit("add_ovf",  3'd7, 3'd7, 3'd7, 2'b00, 3'd5, 1'b1, 1'b0);
        lit("add_wrap", 3'd4, 3'd4, 3'd0, 2'b00, 3'd0, 1'b1, 1'b1);
        lit("sub_borrow", 3'd3, 3'd0, 3'd1, 2'b01, 3'd7, 1'b1, 1'b0);
        lit("sub_equal",  3'd2, 3'd5, 3'd5, 2'b01, 3'd0, 1'b0, 1'b1);
        lit("max_tie", 3'd6, 3'd6, 3'd3, 2'b10, 3'd6, 1'b0, 1'b0);
        lit("maj7",    3'd3, 3'd5, 3'd6, 2'b11, 3'd7, 1'b0, 1'b0);
        lit("max_zero", 3'd0, 3'd0, 3'd0, 2'b10, 3'd0, 1'b0, 1'b1);

        // asynchronous reset while R_EXTRA = 7, mid-cycle with a pending operation
        lit("pre_rst", 3'd0, 3'd0, 3'd7, 2'b00, 3'd7, 1'b0, 1'b0);
        R0 = 3'd7; R1 = 3'd7; R2 = 3'd7; opcode = 2'b00;
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_held", 3'd0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        #1 chk("rst_release", 3'd0, 1'b0, 1'b1);
        @(negedge clk);
        lit("post_rst", 3'd2, 3'd3, 3'd1, 2'b00, 3'd6, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            if ($urandom_range(0, 7) == 0) begin a = '1; b = '1; c = W'($urandom_range(0, 1) * (M - 1)); end
            if ($urandom_range(0, 7) == 0) c = b;
            cyc(a, b, c, 2'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
